// File: rtl/mem_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
// Channel state encoding and the wrapping consumer-index increment.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StReadWait  = 2'd1,
    StWriteWait = 2'd2,
    StRelay     = 2'd3
  } ch_state_e;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester at or after ptr_i,
// wrapping, that is not masked off by busy_i.
module rr_picker #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] busy_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  logic [NumReq-1:0] avail;

  assign avail = req_i & ~busy_i;

  // Walk from the farthest offset back to ptr_i so the nearest candidate wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int unsigned i = NumReq; i > 0; i--) begin
      if (avail[(32'(ptr_i) + i - 32'd1) % NumReq]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IdxW'((32'(ptr_i) + i - 32'd1) % NumReq);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin memory arbiter: NUM_CONSUMERS LSU requesters onto NUM_CHANNELS
// memory channels, each channel running its own IDLE/WAIT/RELAY handshake.
module mem_arbiter_rr
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 1,
  parameter int unsigned WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_addr,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_addr,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_addr,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_addr,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int unsigned IdxW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [NUM_CONSUMERS-1:0] OneHot0 = 1;

  ch_state_e                state_q [NUM_CHANNELS];
  logic [IdxW-1:0]          owner_q [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] busy_q;
  logic [IdxW-1:0]          rr_ptr_q;

  logic [NUM_CONSUMERS-1:0] req;
  logic [NUM_CONSUMERS-1:0] mask [NUM_CHANNELS+1];
  logic [IdxW-1:0]          gnt_idx [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  gnt_valid;
  logic [NUM_CHANNELS-1:0]  claim;

  assign req     = consumer_read_valid | ((WRITE_ENABLE != 0) ? consumer_write_valid : '0);
  assign mask[0] = busy_q;

  // Consumers claimed by lower channels this cycle are masked from higher ones.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    rr_picker #(
      .NumReq (NUM_CONSUMERS),
      .IdxW   (IdxW)
    ) u_picker (
      .req_i       (req),
      .busy_i      (mask[c]),
      .ptr_i       (rr_ptr_q),
      .gnt_idx_o   (gnt_idx[c]),
      .gnt_valid_o (gnt_valid[c])
    );
    assign claim[c]  = (state_q[c] == StIdle) && gnt_valid[c];
    assign mask[c+1] = mask[c] | (claim[c] ? (OneHot0 << gnt_idx[c]) : '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= StIdle;
        owner_q[c] <= '0;
      end
      busy_q               <= '0;
      rr_ptr_q             <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_addr        <= '0;
      mem_write_valid      <= '0;
      mem_write_addr       <= '0;
      mem_write_data       <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        unique case (state_q[c])
          StIdle: begin
            if (claim[c]) begin
              owner_q[c]          <= gnt_idx[c];
              busy_q[gnt_idx[c]]  <= 1'b1;
              rr_ptr_q            <= IdxW'(wrap_inc(32'(gnt_idx[c]), NUM_CONSUMERS));
              if (consumer_read_valid[gnt_idx[c]]) begin
                state_q[c]        <= StReadWait;
                mem_read_valid[c] <= 1'b1;
                mem_read_addr[c*ADDR_BITS +: ADDR_BITS] <=
                    consumer_read_addr[gnt_idx[c]*ADDR_BITS +: ADDR_BITS];
              end else if (WRITE_ENABLE != 0) begin
                state_q[c]         <= StWriteWait;
                mem_write_valid[c] <= 1'b1;
                mem_write_addr[c*ADDR_BITS +: ADDR_BITS] <=
                    consumer_write_addr[gnt_idx[c]*ADDR_BITS +: ADDR_BITS];
                mem_write_data[c*DATA_BITS +: DATA_BITS] <=
                    consumer_write_data[gnt_idx[c]*DATA_BITS +: DATA_BITS];
              end
            end
          end
          StReadWait: begin
            if (mem_read_ready[c]) begin
              consumer_read_data[owner_q[c]*DATA_BITS +: DATA_BITS] <=
                  mem_read_data[c*DATA_BITS +: DATA_BITS];
              consumer_read_ready[owner_q[c]] <= 1'b1;
              mem_read_valid[c]               <= 1'b0;
              state_q[c]                      <= StRelay;
            end
          end
          StWriteWait: begin
            if (mem_write_ready[c]) begin
              consumer_write_ready[owner_q[c]] <= 1'b1;
              mem_write_valid[c]               <= 1'b0;
              state_q[c]                       <= StRelay;
            end
          end
          StRelay: begin
            // The ready bit we raised tells us which valid must drop.
            if (consumer_read_ready[owner_q[c]] ? !consumer_read_valid[owner_q[c]]
                                                : !consumer_write_valid[owner_q[c]]) begin
              consumer_read_ready[owner_q[c]]  <= 1'b0;
              consumer_write_ready[owner_q[c]] <= 1'b0;
              busy_q[owner_q[c]]               <= 1'b0;
              state_q[c]                       <= StIdle;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench: directed handshake/reset/fairness steps plus a
// randomized phase scored against a transaction-level arbiter model.
module tb_mem_arbiter_rr;

  localparam int MFree  = 0;
  localparam int MWait  = 1;
  localparam int MRelay = 2;

  logic clk;
  logic rst_n;

  // DUT A: one channel, writes enabled
  logic [3:0]  a_crv, a_cwv, a_crr, a_cwr;
  logic [31:0] a_craddr, a_cwaddr, a_cwdata, a_crd;
  logic        a_mrv, a_mrr, a_mwv, a_mwr;
  logic [7:0]  a_mra, a_mrd, a_mwa, a_mwd;

  // DUT B: two channels, read-only
  logic [3:0]  b_crv, b_cwv, b_crr, b_cwr;
  logic [31:0] b_craddr, b_cwaddr, b_cwdata, b_crd;
  logic [1:0]  b_mrv, b_mrr, b_mwv, b_mwr;
  logic [15:0] b_mra, b_mrd, b_mwa, b_mwd;

  int n_vec = 0;
  int n_err = 0;

  int m_state, m_ptr, m_owner, m_lat;
  bit m_read;
  int grants[$];

  mem_arbiter_rr #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(1)
  ) u_dut_a (
    .clk(clk), .reset(rst_n),
    .consumer_read_valid(a_crv), .consumer_read_addr(a_craddr),
    .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
    .consumer_write_valid(a_cwv), .consumer_write_addr(a_cwaddr),
    .consumer_write_data(a_cwdata), .consumer_write_ready(a_cwr),
    .mem_read_valid(a_mrv), .mem_read_addr(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_addr(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  mem_arbiter_rr #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .WRITE_ENABLE(0)
  ) u_dut_b (
    .clk(clk), .reset(rst_n),
    .consumer_read_valid(b_crv), .consumer_read_addr(b_craddr),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_addr(b_cwaddr),
    .consumer_write_data(b_cwdata), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_addr(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_addr(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int first_rr(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Transaction-level model of the single-channel arbiter on DUT A.
  task automatic run_cycles(input int n, input bit all_read);
    logic [3:0] s_rv, s_wv;
    logic       s_mrr, s_mwr;
    logic [7:0] s_mdata;
    int idx, rel;
    for (int cyc = 0; cyc < n; cyc++) begin
      s_rv = a_crv; s_wv = a_cwv; s_mrr = a_mrr; s_mwr = a_mwr; s_mdata = a_mrd;
      rel = -1;
      tick();
      case (m_state)
        MFree: begin
          if ((s_rv | s_wv) != 4'b0) begin
            idx     = first_rr(s_rv | s_wv, m_ptr);
            m_owner = idx;
            m_read  = s_rv[idx];
            m_ptr   = (idx + 1) % 4;
            grants.push_back(idx);
            chk("claim_valid", {a_mrv, a_mwv}, m_read ? 2'b10 : 2'b01);
            if (m_read) chk("claim_raddr", a_mra, a_craddr[idx*8 +: 8]);
            else begin
              chk("claim_waddr", a_mwa, a_cwaddr[idx*8 +: 8]);
              chk("claim_wdata", a_mwd, a_cwdata[idx*8 +: 8]);
            end
            m_state = MWait;
            m_lat   = $urandom_range(0, 3);
          end else begin
            chk("idle_quiet", {a_mrv, a_mwv}, 0);
          end
        end
        MWait: begin
          if (m_read ? s_mrr : s_mwr) begin
            if (m_read) begin
              chk("rd_ready", a_crr, 32'(4'b1 << m_owner));
              chk("rd_data", a_crd[m_owner*8 +: 8], s_mdata);
              a_crv[m_owner] = 1'b0;
            end else begin
              chk("wr_ready", a_cwr, 32'(4'b1 << m_owner));
              a_cwv[m_owner] = 1'b0;
            end
            chk("mem_drop", {a_mrv, a_mwv}, 0);
            rel     = m_owner;
            m_state = MRelay;
          end else begin
            chk("wait_hold", {a_mrv, a_mwv}, m_read ? 2'b10 : 2'b01);
            chk("wait_noresp", {a_crr, a_cwr}, 0);
          end
        end
        default: begin
          chk("relay_clear", {a_crr, a_cwr}, 0);
          m_state = MFree;
        end
      endcase
      a_mrr = 1'b0;
      a_mwr = 1'b0;
      if (m_state == MWait) begin
        if (m_lat == 0) begin
          if (m_read) begin a_mrr = 1'b1; a_mrd = 8'($urandom); end
          else a_mwr = 1'b1;
        end else m_lat--;
      end else if (!all_read && $urandom_range(0, 3) == 0) begin
        a_mrr = 1'b1; a_mwr = 1'b1; a_mrd = 8'($urandom);  // must be ignored
      end
      for (int i = 0; i < 4; i++) begin
        if (i != rel && !a_crv[i] && !a_cwv[i]) begin
          if (all_read) begin
            a_crv[i] = 1'b1;
            a_craddr[i*8 +: 8] = 8'h80 + 8'(i);
          end else if ($urandom_range(0, 2) == 0) begin
            idx = $urandom_range(1, 3);
            a_crv[i] = idx[0];
            a_cwv[i] = idx[1];
            a_craddr[i*8 +: 8] = 8'($urandom);
            a_cwaddr[i*8 +: 8] = 8'($urandom);
            a_cwdata[i*8 +: 8] = 8'($urandom);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_crv = '0; a_cwv = '0; a_craddr = '0; a_cwaddr = '0; a_cwdata = '0;
    a_mrr = 1'b0; a_mwr = 1'b0; a_mrd = '0;
    b_crv = '0; b_craddr = '0; b_cwv = 4'hF; b_cwaddr = 32'h44332211; b_cwdata = 32'hDDCCBBAA;
    b_mrr = '0; b_mwr = 2'b11; b_mrd = '0;
    m_state = MFree; m_ptr = 0; m_owner = 0; m_lat = 0; m_read = 1'b0;

    tick();
    chk("rst_mem_valid", {a_mrv, a_mwv, b_mrv, b_mwv}, 0);
    chk("rst_cons_ready", {a_crr, a_cwr, b_crr, b_cwr}, 0);
    chk("rst_rd_data", a_crd, 0);
    chk("rst_mem_addr", {a_mra, a_mwa, a_mwd}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single read: consumer 2, addr 0x10, data 0xAB three cycles later
    a_crv[2] = 1'b1; a_craddr[23:16] = 8'h10;
    tick();
    chk("rd1_mem_valid", {a_mrv, a_mwv}, 2'b10);
    chk("rd1_mem_addr", a_mra, 8'h10);
    tick();
    tick();
    chk("rd1_hold", a_mrv, 1'b1);
    a_mrr = 1'b1; a_mrd = 8'hAB;
    tick();
    chk("rd1_ready", a_crr, 4'b0100);
    chk("rd1_data", a_crd[23:16], 8'hAB);
    chk("rd1_mem_drop", a_mrv, 1'b0);
    a_mrr = 1'b0;
    tick();
    chk("rd1_relay_hold", a_crr, 4'b0100);
    a_crv[2] = 1'b0;
    tick();
    chk("rd1_release", a_crr, 4'b0000);
    chk("rd1_data_kept", a_crd[23:16], 8'hAB);

    // Same-cycle read+write from consumer 0: read first, then write 0x20/0x5A
    a_crv[0] = 1'b1; a_craddr[7:0] = 8'h33;
    a_cwv[0] = 1'b1; a_cwaddr[7:0] = 8'h20; a_cwdata[7:0] = 8'h5A;
    tick();
    chk("rw_read_first", {a_mrv, a_mwv}, 2'b10);
    chk("rw_read_addr", a_mra, 8'h33);
    a_mrr = 1'b1; a_mrd = 8'h11;
    tick();
    chk("rw_rd_ready", {a_crr, a_cwr}, 8'b0001_0000);
    chk("rw_rd_data", a_crd[7:0], 8'h11);
    a_mrr = 1'b0; a_crv[0] = 1'b0;
    tick();
    chk("rw_relay_done", {a_crr, a_mwv}, 0);
    tick();
    chk("rw_write_valid", {a_mrv, a_mwv}, 2'b01);
    chk("rw_write_addr", a_mwa, 8'h20);
    chk("rw_write_data", a_mwd, 8'h5A);
    a_mwr = 1'b1;
    tick();
    chk("rw_wr_ready", {a_cwr, a_mwv}, 5'b0001_0);
    a_mwr = 1'b0; a_cwv[0] = 1'b0;
    tick();
    chk("rw_wr_release", a_cwr, 4'b0000);

    // Reset during READ_WAIT: immediate clear, stale memory ready ignored
    a_crv[1] = 1'b1; a_craddr[15:8] = 8'h44;
    tick();
    chk("rstw_mem_valid", a_mrv, 1'b1);
    chk("rstw_mem_addr", a_mra, 8'h44);
    rst_n = 1'b0; a_mrr = 1'b1; a_mrd = 8'hEE; a_crv[1] = 1'b0;
    #1;
    chk("rstw_async_valid", {a_mrv, a_mwv}, 0);
    chk("rstw_async_addr", a_mra, 0);
    chk("rstw_async_data", a_crd, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstw_no_resp", {a_crr, a_mrv}, 0);
    end
    a_mrr = 1'b0;
    m_state = MFree; m_ptr = 0;

    // Fairness: all four reading continuously
    grants.delete();
    run_cycles(40, 1'b1);
    chk("fair_count", grants.size() >= 5, 1'b1);
    for (int k = 0; k < 5; k++) chk("fair_order", grants[k], k % 4);

    // Randomized traffic
    run_cycles(1500, 1'b0);

    // DUT B: two channels serve consumers 1 and 3 in the same cycle
    b_crv = 4'b1010; b_craddr = 32'h63_00_61_00;
    tick();
    chk("dual_valid", b_mrv, 2'b11);
    chk("dual_addr", b_mra, 16'h6361);
    chk("ro_wvalid", {b_mwv, b_cwr}, 0);
    b_mrr = 2'b11; b_mrd = 16'hD3D1;
    tick();
    chk("dual_ready", b_crr, 4'b1010);
    chk("dual_data", {b_crd[31:24], b_crd[15:8]}, 16'hD3D1);
    b_mrr = 2'b00; b_crv = 4'b0000;
    tick();
    chk("dual_release", {b_crr, b_mrv}, 0);
    // One requester must never be taken by both channels
    b_crv = 4'b0010; b_craddr[15:8] = 8'h71;
    tick();
    chk("single_owner", b_mrv, 2'b01);
    chk("single_addr", b_mra[7:0], 8'h71);
    b_mrr = 2'b01; b_mrd = 16'h00C4;
    tick();
    chk("single_ready", b_crr, 4'b0010);
    chk("single_data", b_crd[15:8], 8'hC4);
    b_mrr = 2'b00; b_crv = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("ro_write_quiet", {b_mwv, b_cwr, b_crr}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
